// File: rtl/tile_map_if.sv
// Bus bundle between the game logic and the tile map engine: sprite
// position queries, map write commands and the level restore request.
interface tile_map_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0]      query_valid;
  logic [11*N_CH-1:0]   query_x;
  logic [11*N_CH-1:0]   query_y;
  logic [N_CH-1:0]      result_valid;
  logic [N_CH-1:0]      result_blocked;
  logic [1:0]           wr_cmd;
  logic [10:0]          wr_x;
  logic [10:0]          wr_y;
  logic                 wr_ack;
  logic                 wr_ok;
  logic                 level_restore;
  logic                 busy;

  modport master (
    output query_valid, query_x, query_y, wr_cmd, wr_x, wr_y, level_restore,
    input  result_valid, result_blocked, wr_ack, wr_ok, busy
  );

  modport slave (
    input  query_valid, query_x, query_y, wr_cmd, wr_x, wr_y, level_restore,
    output result_valid, result_blocked, wr_ack, wr_ok, busy
  );
endinterface

// File: rtl/tile_map_engine.sv
// Mutable game-board tile map: per-channel four-corner collision queries,
// bomb place / tile clear writes, and a row-by-row default level restore.
//
// state | meaning
// IDLE  | map serves queries and writes, busy=0
// SCAN  | one default-level row reloaded per cycle, busy=1
module tile_map_engine #(
  parameter int TILE_BITS  = 5,
  parameter int MAP_COLS   = 19,
  parameter int MAP_ROWS   = 13,
  parameter int ORIGIN_X   = 15,
  parameter int ORIGIN_Y   = 48,
  parameter int N_CH       = 2,
  parameter int BRICK_FILL = 1
) (
  input logic      clk,
  input logic      reset,
  tile_map_if.slave bus
);

  localparam int RW = $clog2(MAP_ROWS);
  localparam int CW = $clog2(MAP_COLS);
  localparam logic [11:0] ORIGIN_X12 = 12'(ORIGIN_X);
  localparam logic [11:0] ORIGIN_Y12 = 12'(ORIGIN_Y);
  localparam logic [11:0] COLS12     = 12'(MAP_COLS);
  localparam logic [11:0] ROWS12     = 12'(MAP_ROWS);
  localparam logic [11:0] SPAN       = 12'((1 << TILE_BITS) - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(MAP_ROWS - 1);

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_WALL  = 2'd1;
  localparam logic [1:0] TILE_BRICK = 2'd2;
  localparam logic [1:0] TILE_BOMB  = 2'd3;

  typedef struct packed {
    logic          inMap;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } locType;

  typedef enum logic {IDLE, SCAN} stateType;

  logic [1:0]      tileMap [MAP_ROWS][MAP_COLS];
  stateType        state, stateNext;
  logic [RW-1:0]   rowCnt, rowCntNext;
  logic            loadRow;
  logic            busy;
  logic [N_CH-1:0] blockedNext;
  logic [N_CH-1:0] resultValid;
  logic [N_CH-1:0] resultBlocked;
  locType          wrLoc;
  logic [1:0]      wrTile;
  logic [1:0]      wrNewTile;
  logic            wrCmdValid;
  logic            wrOkNext;
  logic            wrAck;
  logic            wrOk;

  // Only ever called with constant arguments, so it folds to a fixed pattern.
  function automatic logic [1:0] defaultTile(input int r, input int c);
    if ((r == 0 && c <= 1) || (r == 1 && c == 0)) return TILE_EMPTY;
    if ((r % 2 == 1) && (c % 2 == 1)) return TILE_WALL;
    if (BRICK_FILL != 0 && (r + c) >= 3 && ((r + c) % 3) != 0) return TILE_BRICK;
    return TILE_EMPTY;
  endfunction

  // A negative offset shows up as bit 11 of the 12-bit difference.
  function automatic locType locate(input logic [11:0] px, input logic [11:0] py);
    logic [11:0] dx, dy, colFull, rowFull;
    locType l;
    dx      = px - ORIGIN_X12;
    dy      = py - ORIGIN_Y12;
    colFull = dx >> TILE_BITS;
    rowFull = dy >> TILE_BITS;
    l.inMap = !dx[11] && !dy[11] && (colFull < COLS12) && (rowFull < ROWS12);
    l.row   = rowFull[RW-1:0];
    l.col   = colFull[CW-1:0];
    return l;
  endfunction

  function automatic logic occupied(input logic [11:0] px, input logic [11:0] py);
    locType l;
    l = locate(px, py);
    if (!l.inMap) return 1'b1;
    return tileMap[l.row][l.col] != TILE_EMPTY;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : gQuery
    logic [11:0] qx0, qy0, qx1, qy1;
    assign qx0 = {1'b0, bus.query_x[11*g +: 11]};
    assign qy0 = {1'b0, bus.query_y[11*g +: 11]};
    assign qx1 = qx0 + SPAN;
    assign qy1 = qy0 + SPAN;
    assign blockedNext[g] = occupied(qx0, qy0) | occupied(qx1, qy0) |
                            occupied(qx0, qy1) | occupied(qx1, qy1);
  end

  assign busy = (state == SCAN);

  // Decode the write command against the current (pre-write) map contents.
  always_comb begin
    wrLoc      = locate({1'b0, bus.wr_x}, {1'b0, bus.wr_y});
    wrTile     = wrLoc.inMap ? tileMap[wrLoc.row][wrLoc.col] : TILE_EMPTY;
    wrCmdValid = (bus.wr_cmd == 2'b01) || (bus.wr_cmd == 2'b10);
    wrOkNext   = 1'b0;
    wrNewTile  = TILE_EMPTY;
    case (bus.wr_cmd)
      2'b01: begin
        wrOkNext  = !busy && wrLoc.inMap && (wrTile == TILE_EMPTY);
        wrNewTile = TILE_BOMB;
      end
      2'b10: begin
        wrOkNext  = !busy && wrLoc.inMap &&
                    ((wrTile == TILE_BRICK) || (wrTile == TILE_BOMB));
        wrNewTile = TILE_EMPTY;
      end
      default: ;
    endcase
  end

  // Restore FSM next-state: walk the rows once, ignoring repeat requests.
  always_comb begin
    stateNext  = state;
    rowCntNext = rowCnt;
    loadRow    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.level_restore) begin
          stateNext  = SCAN;
          rowCntNext = '0;
        end
      end
      SCAN: begin
        loadRow = 1'b1;
        if (rowCnt == LAST_ROW) begin
          stateNext  = IDLE;
          rowCntNext = '0;
        end else begin
          rowCntNext = rowCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Restore FSM state and row counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rowCnt <= '0;
    end else begin
      state  <= stateNext;
      rowCnt <= rowCntNext;
    end
  end

  // Map storage: reset and scan load the default level; writes only when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < MAP_ROWS; r++)
        for (int c = 0; c < MAP_COLS; c++)
          tileMap[r][c] <= defaultTile(r, c);
    end else if (loadRow) begin
      for (int r = 0; r < MAP_ROWS; r++)
        for (int c = 0; c < MAP_COLS; c++)
          if (rowCnt == RW'(r)) tileMap[r][c] <= defaultTile(r, c);
    end else if (wrOkNext) begin
      tileMap[wrLoc.row][wrLoc.col] <= wrNewTile;
    end
  end

  // Registered query results (held while idle) and write responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultValid   <= '0;
      resultBlocked <= '0;
      wrAck         <= 1'b0;
      wrOk          <= 1'b0;
    end else begin
      resultValid <= bus.query_valid;
      for (int i = 0; i < N_CH; i++)
        if (bus.query_valid[i]) resultBlocked[i] <= busy | blockedNext[i];
      wrAck <= wrCmdValid;
      wrOk  <= wrOkNext;
    end
  end

  assign bus.result_valid   = resultValid;
  assign bus.result_blocked = resultBlocked;
  assign bus.wr_ack         = wrAck;
  assign bus.wr_ok          = wrOk;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_tile_map_engine.sv
// Bench for tile_map_engine: directed steps then random traffic, each cycle
// compared with a tile-grid model of the board.
module tb_tile_map_engine;
  localparam int COLS = 19;
  localparam int ROWS = 13;
  localparam int OX   = 15;
  localparam int OY   = 48;
  localparam int T    = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tile_map_if #(.N_CH(2)) bus();

  tile_map_engine #(
    .TILE_BITS(5), .MAP_COLS(COLS), .MAP_ROWS(ROWS), .ORIGIN_X(OX),
    .ORIGIN_Y(OY), .N_CH(2), .BRICK_FILL(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int refMap [ROWS][COLS];
  int scanRow = -1;
  logic [1:0] expBlk = 2'b00;
  logic [1:0] lastBlk;
  logic lastOk;
  int busyCount;

  function automatic int defTile(int r, int c);
    if ((r == 0 && c <= 1) || (r == 1 && c == 0)) return 0;
    if (r % 2 == 1 && c % 2 == 1) return 1;
    if (r + c >= 3 && (r + c) % 3 != 0) return 2;
    return 0;
  endfunction

  function automatic int tileIdx(int x, int y);
    int dx, dy;
    dx = x - OX;
    dy = y - OY;
    if (dx < 0 || dy < 0) return -1;
    if (dx / T >= COLS || dy / T >= ROWS) return -1;
    return (dy / T) * COLS + (dx / T);
  endfunction

  function automatic bit blockedAt(int x, int y);
    int xs[2], ys[2], idx;
    xs[0] = x; xs[1] = x + T - 1;
    ys[0] = y; ys[1] = y + T - 1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        idx = tileIdx(xs[i], ys[j]);
        if (idx < 0) return 1'b1;
        if (refMap[idx / COLS][idx % COLS] != 0) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        refMap[r][c] = defTile(r, c);
    scanRow = -1;
    expBlk  = 2'b00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] qv, input int x0, input int y0,
                      input int x1, input int y1, input logic [1:0] cmd,
                      input int wx, input int wy, input logic restore);
    int qx[2], qy[2], idx, t;
    bit busyNow, expAck, expOk;
    qx[0] = x0; qx[1] = x1; qy[0] = y0; qy[1] = y1;
    bus.query_valid   = qv;
    bus.query_x       = {11'(x1), 11'(x0)};
    bus.query_y       = {11'(y1), 11'(y0)};
    bus.wr_cmd        = cmd;
    bus.wr_x          = 11'(wx);
    bus.wr_y          = 11'(wy);
    bus.level_restore = restore;

    busyNow = (scanRow >= 0);
    for (int ch = 0; ch < 2; ch++)
      if (qv[ch]) expBlk[ch] = busyNow ? 1'b1 : blockedAt(qx[ch], qy[ch]);
    expAck = (cmd == 2'd1) || (cmd == 2'd2);
    idx = tileIdx(wx, wy);
    t = (idx >= 0) ? refMap[idx / COLS][idx % COLS] : -1;
    expOk = 1'b0;
    if (!busyNow && idx >= 0) begin
      if (cmd == 2'd1) expOk = (t == 0);
      if (cmd == 2'd2) expOk = (t == 2 || t == 3);
    end

    if (busyNow) begin
      for (int c = 0; c < COLS; c++) refMap[scanRow][c] = defTile(scanRow, c);
      scanRow = (scanRow == ROWS - 1) ? -1 : scanRow + 1;
    end else begin
      if (expOk) refMap[idx / COLS][idx % COLS] = (cmd == 2'd1) ? 3 : 0;
      if (restore) scanRow = 0;
    end

    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("valid_ch%0d", ch), 32'(bus.result_valid[ch]), 32'(qv[ch]));
      check($sformatf("blocked_ch%0d", ch), 32'(bus.result_blocked[ch]), 32'(expBlk[ch]));
    end
    check("wr_ack", 32'(bus.wr_ack), 32'(expAck));
    if (expAck) check("wr_ok", 32'(bus.wr_ok), 32'(expOk));
    check("busy", 32'(bus.busy), 32'(scanRow >= 0));
    lastBlk = bus.result_blocked;
    lastOk  = bus.wr_ok;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 2'd0, 0, 0, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_valid"},   32'(bus.result_valid),   32'd0);
    check({tag, "_blocked"}, 32'(bus.result_blocked), 32'd0);
    check({tag, "_ack"},     32'(bus.wr_ack),         32'd0);
    check({tag, "_ok"},      32'(bus.wr_ok),          32'd0);
    check({tag, "_busy"},    32'(bus.busy),           32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.query_valid = '0; bus.query_x = '0; bus.query_y = '0;
    bus.wr_cmd = 2'd0; bus.wr_x = '0; bus.wr_y = '0; bus.level_restore = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetOutputs("reset");
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // basic queries
    step(2'b01, 15, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_origin", 32'(lastBlk[0]), 32'd0);
    step(2'b10, 0, 0, 47, 80, 2'd0, 0, 0, 1'b0);
    check("plan_wall", 32'(lastBlk[1]), 32'd1);
    step(2'b01, 14, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_offleft", 32'(lastBlk[0]), 32'd1);
    step(2'b01, 15 + 18 * 32, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_col18", 32'(lastBlk[0]), 32'd0);
    step(2'b01, 16 + 18 * 32, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_col19", 32'(lastBlk[0]), 32'd1);

    // bomb place / clear
    step(2'b00, 0, 0, 0, 0, 2'd1, 20, 50, 1'b0);
    check("plan_place_ok", 32'(lastOk), 32'd1);
    step(2'b01, 15, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_bomb_blocks", 32'(lastBlk[0]), 32'd1);
    step(2'b00, 0, 0, 0, 0, 2'd1, 20, 50, 1'b0);
    check("plan_place_again", 32'(lastOk), 32'd0);
    step(2'b00, 0, 0, 0, 0, 2'd2, 20, 50, 1'b0);
    check("plan_clear_bomb", 32'(lastOk), 32'd1);
    step(2'b01, 15, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_cleared", 32'(lastBlk[0]), 32'd0);

    // same-cycle write and query
    step(2'b01, 15, 48, 0, 0, 2'd1, 20, 50, 1'b0);
    check("plan_prewrite", 32'(lastBlk[0]), 32'd0);
    step(2'b01, 15, 48, 0, 0, 2'd0, 0, 0, 1'b0);
    check("plan_postwrite", 32'(lastBlk[0]), 32'd1);

    // clears on wall, empty and brick tiles
    step(2'b00, 0, 0, 0, 0, 2'd2, 50, 85, 1'b0);
    check("plan_clear_wall", 32'(lastOk), 32'd0);
    step(2'b00, 0, 0, 0, 0, 2'd2, 80, 50, 1'b0);
    step(2'b00, 0, 0, 0, 0, 2'd2, 148, 50, 1'b0);
    check("plan_clear_brick", 32'(lastOk), 32'd1);
    step(2'b00, 0, 0, 0, 0, 2'd3, 20, 50, 1'b0);

    // restore with writes and a repeat request inside the scan window
    step(2'b00, 0, 0, 0, 0, 2'd0, 0, 0, 1'b1);
    busyCount = int'(bus.busy);
    for (int k = 0; k < 13; k++) begin
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
           int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
           2'($urandom_range(1, 2)), 15 + 32 * int'($urandom_range(0, 18)),
           48 + 32 * int'($urandom_range(0, 12)), (k == 3));
      busyCount += int'(bus.busy);
    end
    check("plan_busy_cycles", 32'(busyCount), 32'd13);
    step(2'b11, 15, 48, 144, 48, 2'd0, 0, 0, 1'b0);
    check("plan_restored_empty", 32'(lastBlk[0]), 32'd0);
    check("plan_restored_brick", 32'(lastBlk[1]), 32'd1);

    // reset in the middle of a scan
    step(2'b00, 0, 0, 0, 0, 2'd1, 20, 50, 1'b0);
    step(2'b00, 0, 0, 0, 0, 2'd0, 0, 0, 1'b1);
    idle(5);
    #2 reset = 1'b1;
    #1 checkResetOutputs("midscan");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < ROWS * COLS; k += 2) begin
      int k1;
      k1 = (k + 1 < ROWS * COLS) ? k + 1 : k;
      step(2'b11, OX + T * (k % COLS), OY + T * (k / COLS),
           OX + T * (k1 % COLS), OY + T * (k1 / COLS), 2'd0, 0, 0, 1'b0);
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
           int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
           2'($urandom_range(0, 3)),
           OX + 32 * int'($urandom_range(0, 19)) + int'($urandom_range(0, 31)) - 2,
           OY + 32 * int'($urandom_range(0, 13)) + int'($urandom_range(0, 31)) - 2,
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
